// File: rtl/dmg_main.sv
// dmg_main: minimal DMG-style (SM83 subset) CPU core executing straight from
// cartridge ROM. Every byte read takes two cycles: an ADDR cycle that presents
// PC on rom_addr, then a DATA cycle that holds the address, captures rom_data
// at the closing edge and advances PC.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   rom_addr  out  ROM byte address, PC[14:0] (0x8000+ aliases into ROM)
//   rom_data  in   ROM data, valid the cycle after rom_addr is presented
//   dbg_pc    out  current PC
//   dbg_a     out  register A
//   dbg_f     out  flags Z N H C in bits 7:4, bits 3:0 read as 0
//   halted    out  set once HALT executes, cleared only by rst
module dmg_main (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [15:0] dbg_pc,
    output logic [7:0]  dbg_a,
    output logic [7:0]  dbg_f,
    output logic        halted
);

    typedef enum logic [2:0] {
        OP_ADDR,
        OP_DATA,
        IMM1_ADDR,
        IMM1_DATA,
        IMM2_ADDR,
        IMM2_DATA,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_ADC,
        ALU_SUB,
        ALU_SBC,
        ALU_AND,
        ALU_XOR,
        ALU_OR,
        ALU_CP
    } alu_op_t;

    state_t      state;
    logic [15:0] pc;
    logic [7:0]  a, b, c, d, e, h, l;
    logic [3:0]  flags;                  // {Z, N, H, C}
    logic [7:0]  opcode;
    logic [7:0]  imm_lo;
    logic        halt_q;

    // Datapath / decode signals
    logic [7:0]  src_val;                // register selected by op[2:0]
    logic [7:0]  dst_val;                // register selected by op[5:3]
    alu_op_t     alu_sel;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic        h_add;
    logic        h_sub;
    logic [7:0]  alu_res;
    logic [3:0]  alu_flags;
    logic [7:0]  inc_res;
    logic [7:0]  dec_res;
    logic        op_needs_imm;
    logic        is_jr;
    logic        jr_taken;
    logic [15:0] jr_target;

    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [7:0]  wr_val;
    logic        f_wr;
    logic [3:0]  f_next;

    assign rom_addr = pc[14:0];
    assign dbg_pc   = pc;
    assign dbg_a    = a;
    assign dbg_f    = {flags, 4'b0000};
    assign halted   = halt_q;

    always_comb begin
        // Register file reads for the opcode currently on rom_data
        case (rom_data[2:0])
            3'd0:    src_val = b;
            3'd1:    src_val = c;
            3'd2:    src_val = d;
            3'd3:    src_val = e;
            3'd4:    src_val = h;
            3'd5:    src_val = l;
            3'd7:    src_val = a;
            default: src_val = 8'h00;
        endcase
        case (rom_data[5:3])
            3'd0:    dst_val = b;
            3'd1:    dst_val = c;
            3'd2:    dst_val = d;
            3'd3:    dst_val = e;
            3'd4:    dst_val = h;
            3'd5:    dst_val = l;
            3'd7:    dst_val = a;
            default: dst_val = 8'h00;
        endcase

        // ALU: register operand during OP_DATA, immediate during IMM1_DATA
        if (state == IMM1_DATA) begin
            alu_sel = alu_op_t'(opcode[5:3]);
            alu_b   = rom_data;
        end else begin
            alu_sel = alu_op_t'(rom_data[5:3]);
            alu_b   = src_val;
        end
        alu_cin = ((alu_sel == ALU_ADC) || (alu_sel == ALU_SBC)) ? flags[0] : 1'b0;
        sum9    = {1'b0, a} + {1'b0, alu_b} + {8'h00, alu_cin};
        diff9   = {1'b0, a} - {1'b0, alu_b} - {8'h00, alu_cin};
        h_add   = ({1'b0, a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_cin}) > 5'h0F;
        h_sub   = {1'b0, a[3:0]} < ({1'b0, alu_b[3:0]} + {4'h0, alu_cin});

        case (alu_sel)
            ALU_ADD, ALU_ADC: begin
                alu_res   = sum9[7:0];
                alu_flags = {1'b0, 1'b0, h_add, sum9[8]};
            end
            ALU_SUB, ALU_SBC, ALU_CP: begin
                alu_res   = diff9[7:0];
                alu_flags = {1'b0, 1'b1, h_sub, diff9[8]};
            end
            ALU_AND: begin
                alu_res   = a & alu_b;
                alu_flags = 4'b0010;
            end
            ALU_XOR: begin
                alu_res   = a ^ alu_b;
                alu_flags = 4'b0000;
            end
            default: begin
                alu_res   = a | alu_b;
                alu_flags = 4'b0000;
            end
        endcase
        alu_flags[3] = (alu_res == 8'h00);

        inc_res = dst_val + 8'd1;
        dec_res = dst_val - 8'd1;

        op_needs_imm = ((rom_data[7:6] == 2'b00) && (rom_data[2:0] == 3'b110) &&
                        (rom_data[5:3] != 3'd6)) ||
                       ((rom_data[7:6] == 2'b11) && (rom_data[2:0] == 3'b110)) ||
                       (rom_data == 8'h18) ||
                       ((rom_data[7:5] == 3'b001) && (rom_data[2:0] == 3'b000)) ||
                       (rom_data == 8'hC3);

        // JR resolution uses the latched opcode while its operand is on rom_data
        is_jr = (opcode == 8'h18) ||
                ((opcode[7:5] == 3'b001) && (opcode[2:0] == 3'b000));
        if (opcode == 8'h18) begin
            jr_taken = 1'b1;
        end else begin
            case (opcode[4:3])
                2'b00:   jr_taken = ~flags[3];
                2'b01:   jr_taken = flags[3];
                2'b10:   jr_taken = ~flags[0];
                default: jr_taken = flags[0];
            endcase
        end
        jr_target = pc + 16'd1 + {{8{rom_data[7]}}, rom_data};

        // Single pending register/flag write for this cycle
        wr_en  = 1'b0;
        wr_idx = 3'd7;
        wr_val = 8'h00;
        f_wr   = 1'b0;
        f_next = flags;

        if (state == OP_DATA) begin
            if (rom_data[7:6] == 2'b01) begin
                // LD r,r'; any (HL) operand or destination (incl. 76) writes nothing
                if ((rom_data[5:3] != 3'd6) && (rom_data[2:0] != 3'd6)) begin
                    wr_en  = 1'b1;
                    wr_idx = rom_data[5:3];
                    wr_val = src_val;
                end
            end else if (rom_data[7:6] == 2'b10) begin
                if (rom_data[2:0] != 3'd6) begin
                    wr_en  = (alu_sel != ALU_CP);
                    wr_idx = 3'd7;
                    wr_val = alu_res;
                    f_wr   = 1'b1;
                    f_next = alu_flags;
                end
            end else if ((rom_data[7:6] == 2'b00) && (rom_data[5:3] != 3'd6)) begin
                if (rom_data[2:0] == 3'b100) begin
                    wr_en  = 1'b1;
                    wr_idx = rom_data[5:3];
                    wr_val = inc_res;
                    f_wr   = 1'b1;
                    f_next = {(inc_res == 8'h00), 1'b0, (dst_val[3:0] == 4'hF), flags[0]};
                end else if (rom_data[2:0] == 3'b101) begin
                    wr_en  = 1'b1;
                    wr_idx = rom_data[5:3];
                    wr_val = dec_res;
                    f_wr   = 1'b1;
                    f_next = {(dec_res == 8'h00), 1'b1, (dst_val[3:0] == 4'h0), flags[0]};
                end
            end
        end else if (state == IMM1_DATA) begin
            if ((opcode[7:6] == 2'b00) && (opcode[2:0] == 3'b110)) begin
                wr_en  = 1'b1;
                wr_idx = opcode[5:3];
                wr_val = rom_data;
            end else if (opcode[7:6] == 2'b11 && opcode != 8'hC3) begin
                wr_en  = (alu_sel != ALU_CP);
                wr_idx = 3'd7;
                wr_val = alu_res;
                f_wr   = 1'b1;
                f_next = alu_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= OP_ADDR;
            pc     <= '0;
            a      <= '0;
            b      <= '0;
            c      <= '0;
            d      <= '0;
            e      <= '0;
            h      <= '0;
            l      <= '0;
            flags  <= '0;
            opcode <= '0;
            imm_lo <= '0;
            halt_q <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_idx)
                    3'd0:    b <= wr_val;
                    3'd1:    c <= wr_val;
                    3'd2:    d <= wr_val;
                    3'd3:    e <= wr_val;
                    3'd4:    h <= wr_val;
                    3'd5:    l <= wr_val;
                    3'd7:    a <= wr_val;
                    default: ;
                endcase
            end
            if (f_wr) begin
                flags <= f_next;
            end

            case (state)
                OP_ADDR: state <= OP_DATA;
                OP_DATA: begin
                    pc     <= pc + 16'd1;
                    opcode <= rom_data;
                    if (rom_data == 8'h76) begin
                        state  <= HALT;
                        halt_q <= 1'b1;
                    end else if (op_needs_imm) begin
                        state <= IMM1_ADDR;
                    end else begin
                        state <= OP_ADDR;
                    end
                end
                IMM1_ADDR: state <= IMM1_DATA;
                IMM1_DATA: begin
                    if (opcode == 8'hC3) begin
                        imm_lo <= rom_data;
                        pc     <= pc + 16'd1;
                        state  <= IMM2_ADDR;
                    end else begin
                        pc    <= (is_jr && jr_taken) ? jr_target : pc + 16'd1;
                        state <= OP_ADDR;
                    end
                end
                IMM2_ADDR: state <= IMM2_DATA;
                IMM2_DATA: begin
                    pc    <= {rom_data, imm_lo};
                    state <= OP_ADDR;
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_dmg_main.sv
module tb_dmg_main;

    logic        clk;
    logic        rst;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic [15:0] dbg_pc;
    logic [7:0]  dbg_a;
    logic [7:0]  dbg_f;
    logic        halted;

    logic [7:0]  rom [0:32767];

    int checks = 0;
    int errors = 0;
    int cyc;

    dmg_main dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .dbg_pc   (dbg_pc),
        .dbg_a    (dbg_a),
        .dbg_f    (dbg_f),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read latency
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 32768; i++) rom[i] = 8'h00;
    endtask

    // Leaves the bench at the negedge where rst has just dropped (ADDR of first fetch)
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (halted !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b1;
        rom_clear();

        // Reset state and first fetch addresses (ROM all NOP)
        do_reset();
        check("rst_pc", dbg_pc, 16'h0000);
        check("rst_addr0", {1'b0, rom_addr}, 16'h0000);
        check("rst_a", {8'h00, dbg_a}, 16'h0000);
        check("rst_f", {8'h00, dbg_f}, 16'h0000);
        check("rst_halted", {15'h0, halted}, 16'h0000);
        step(1);
        check("rst_addr1", {1'b0, rom_addr}, 16'h0000);
        step(1);
        check("rst_addr2", {1'b0, rom_addr}, 16'h0001);
        check("rst_pc2", dbg_pc, 16'h0001);

        // LD A,0F ; ADD A,01 ; HALT
        rom_clear();
        rom[0] = 8'h3E; rom[1] = 8'h0F; rom[2] = 8'hC6; rom[3] = 8'h01; rom[4] = 8'h76;
        do_reset();
        run_to_halt(50, cyc);
        check("ldadd_cycles", cyc[15:0], 16'd10);
        check("ldadd_a", {8'h00, dbg_a}, 16'h0010);
        check("ldadd_f", {8'h00, dbg_f}, 16'h0020);
        check("ldadd_halted", {15'h0, halted}, 16'h0001);
        check("ldadd_pc", dbg_pc, 16'h0005);
        check("ldadd_addr", {1'b0, rom_addr}, 16'h0005);
        step(4);
        check("halt_hold_addr", {1'b0, rom_addr}, 16'h0005);
        check("halt_hold_pc", dbg_pc, 16'h0005);

        // LD A,05 ; SUB 05 ; CP 01 ; HALT
        rom_clear();
        rom[0] = 8'h3E; rom[1] = 8'h05; rom[2] = 8'hD6; rom[3] = 8'h05;
        rom[4] = 8'hFE; rom[5] = 8'h01; rom[6] = 8'h76;
        do_reset();
        step(8);
        check("sub_a", {8'h00, dbg_a}, 16'h0000);
        check("sub_f", {8'h00, dbg_f}, 16'h00C0);
        run_to_halt(50, cyc);
        check("cp_cycles", cyc[15:0], 16'd6);
        check("cp_a", {8'h00, dbg_a}, 16'h0000);
        check("cp_f", {8'h00, dbg_f}, 16'h0070);
        check("cp_pc", dbg_pc, 16'h0007);

        // JP 1234 ; at 1234: JR -2 (self loop)
        rom_clear();
        rom[0] = 8'hC3; rom[1] = 8'h34; rom[2] = 8'h12;
        rom[16'h1234] = 8'h18; rom[16'h1235] = 8'hFE;
        do_reset();
        check("jp_addr0", {1'b0, rom_addr}, 16'h0000);
        step(5);
        check("jp_addr5", {1'b0, rom_addr}, 16'h0002);
        step(1);
        check("jp_addr6", {1'b0, rom_addr}, 16'h1234);
        check("jp_pc6", dbg_pc, 16'h1234);
        step(2);
        check("jr_operand", {1'b0, rom_addr}, 16'h1235);
        step(2);
        check("jr_loop1", {1'b0, rom_addr}, 16'h1234);
        step(2);
        check("jr_loop_op", {1'b0, rom_addr}, 16'h1235);
        step(2);
        check("jr_loop2", dbg_pc, 16'h1234);

        // XOR A ; JR Z,+2 (taken) ; INC A x2 (skipped) ; JR NZ,+2 (not taken) ; HALT
        rom_clear();
        rom[0] = 8'hAF; rom[1] = 8'h28; rom[2] = 8'h02; rom[3] = 8'h3C; rom[4] = 8'h3C;
        rom[5] = 8'h20; rom[6] = 8'h02; rom[7] = 8'h76; rom[8] = 8'h3C;
        do_reset();
        step(2);
        check("xor_f", {8'h00, dbg_f}, 16'h0080);
        check("xor_pc", dbg_pc, 16'h0001);
        step(4);
        check("jrz_taken_pc", dbg_pc, 16'h0005);
        step(4);
        check("jrnz_fall_pc", dbg_pc, 16'h0007);
        step(2);
        check("jrc_halted", {15'h0, halted}, 16'h0001);
        check("jrc_a", {8'h00, dbg_a}, 16'h0000);
        check("jrc_pc", dbg_pc, 16'h0008);

        // Reset during IMM2_DATA of JP aborts the jump
        rom_clear();
        rom[0] = 8'hC3; rom[1] = 8'h34; rom[2] = 8'h12;
        do_reset();
        step(5);
        check("mid_pc_before", dbg_pc, 16'h0002);
        rst = 1'b1;
        step(1);
        check("mid_pc_after", dbg_pc, 16'h0000);
        check("mid_addr_after", {1'b0, rom_addr}, 16'h0000);
        rst = 1'b0;
        step(6);
        check("mid_rejump", {1'b0, rom_addr}, 16'h1234);

        // NOP at 0x7FFF: PC goes to 0x8000, rom_addr wraps to 0
        rom_clear();
        rom[0] = 8'hC3; rom[1] = 8'hFF; rom[2] = 8'h7F; rom[16'h7FFF] = 8'h00;
        do_reset();
        step(6);
        check("wrap_pc0", dbg_pc, 16'h7FFF);
        check("wrap_addr0", {1'b0, rom_addr}, 16'h7FFF);
        step(2);
        check("wrap_pc1", dbg_pc, 16'h8000);
        check("wrap_addr1", {1'b0, rom_addr}, 16'h0000);

        // INC/DEC, LD r,r', ADD r, ADC/SBC with carry, AND/OR/XOR, (HL) NOP
        rom_clear();
        rom[0]  = 8'h06; rom[1]  = 8'h0F;   // LD B,0F
        rom[2]  = 8'h04;                    // INC B
        rom[3]  = 8'h78;                    // LD A,B
        rom[4]  = 8'h05;                    // DEC B
        rom[5]  = 8'h80;                    // ADD A,B
        rom[6]  = 8'hC6; rom[7]  = 8'hE1;   // ADD A,E1
        rom[8]  = 8'hDE; rom[9]  = 8'h00;   // SBC A,00
        rom[10] = 8'hCE; rom[11] = 8'h00;   // ADC A,00
        rom[12] = 8'hE6; rom[13] = 8'h0F;   // AND 0F
        rom[14] = 8'hF6; rom[15] = 8'hF0;   // OR F0
        rom[16] = 8'hEE; rom[17] = 8'hF1;   // XOR F1
        rom[18] = 8'h7E;                    // LD A,(HL) -> NOP
        rom[19] = 8'h76;                    // HALT
        do_reset();
        step(6);
        check("inc_f", {8'h00, dbg_f}, 16'h0020);
        step(2);
        check("ldrr_a", {8'h00, dbg_a}, 16'h0010);
        step(2);
        check("dec_f", {8'h00, dbg_f}, 16'h0060);
        step(2);
        check("addr_a", {8'h00, dbg_a}, 16'h001F);
        check("addr_f", {8'h00, dbg_f}, 16'h0000);
        step(4);
        check("addd8_a", {8'h00, dbg_a}, 16'h0000);
        check("addd8_f", {8'h00, dbg_f}, 16'h00B0);
        step(4);
        check("sbc_a", {8'h00, dbg_a}, 16'h00FF);
        check("sbc_f", {8'h00, dbg_f}, 16'h0070);
        step(4);
        check("adc_a", {8'h00, dbg_a}, 16'h0000);
        check("adc_f", {8'h00, dbg_f}, 16'h00B0);
        step(4);
        check("and_f", {8'h00, dbg_f}, 16'h00A0);
        step(4);
        check("or_a", {8'h00, dbg_a}, 16'h00F0);
        check("or_f", {8'h00, dbg_f}, 16'h0000);
        step(4);
        check("xor_a", {8'h00, dbg_a}, 16'h0001);
        step(2);
        check("hl_nop_a", {8'h00, dbg_a}, 16'h0001);
        check("hl_nop_pc", dbg_pc, 16'h0013);
        step(2);
        check("prog_halted", {15'h0, halted}, 16'h0001);
        check("prog_pc", dbg_pc, 16'h0014);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
